// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, latches memory words into IF/ID,
// and halts on an illegal fetch address until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 400,
  parameter logic [31:0] NOP_WORD  = 32'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic [31:0] INSTR_IN,
  output logic [31:0] PC,
  output logic [31:0] IFID_INSTR,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic        IFID_VALID,
  output logic        FAULT,
  output logic [31:0] FETCH_COUNT
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t state_q;
  state_t state_d;
  logic   legal;
  logic   do_redirect;
  logic   do_fault;
  logic   do_fetch;

  assign legal = (PC[1:0] == 2'b00) && (PC <= LAST_PC);

  // State register; HALT is left only through reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-edge action: redirect beats stall beats fault check.
  always_comb begin
    state_d     = state_q;
    do_redirect = 1'b0;
    do_fault    = 1'b0;
    do_fetch    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (REDIRECT) begin
          do_redirect = 1'b1;
        end else if (!STALL) begin
          if (!legal) begin
            do_fault = 1'b1;
            state_d  = HALT;
          end else begin
            do_fetch = 1'b1;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // PC, IF/ID register, fault flag and issue counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC          <= RESET_PC;
      IFID_INSTR  <= NOP_WORD;
      IFID_PC     <= 32'd0;
      IFID_PC4    <= 32'd0;
      IFID_VALID  <= 1'b0;
      FAULT       <= 1'b0;
      FETCH_COUNT <= 32'd0;
    end else if (do_redirect) begin
      PC         <= REDIRECT_PC;
      IFID_VALID <= 1'b0;
      IFID_INSTR <= NOP_WORD;
    end else if (do_fault) begin
      FAULT      <= 1'b1;
      IFID_VALID <= 1'b0;
      IFID_INSTR <= NOP_WORD;
    end else if (do_fetch) begin
      IFID_INSTR  <= INSTR_IN;
      IFID_PC     <= PC;
      IFID_PC4    <= PC + 32'd4;
      IFID_VALID  <= 1'b1;
      PC          <= PC + 32'd4;
      FETCH_COUNT <= FETCH_COUNT + 32'd1;
    end
  end

endmodule
